ps2_key_flag_ctrl: RTL and testbench



---
 rtl/ps2_pkg.sv | 18 +
 rtl/ps2_seq_timer.sv | 35 +++
 rtl/ps2_key_flag_ctrl.sv | 117 +++++++++++
 tb/tb_ps2_key_flag_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants and the prefix-sequence FSM encoding.
package ps2_pkg;

  localparam logic [7:0] PS2_BRK      = 8'hF0;
  localparam logic [7:0] PS2_EXT      = 8'hE0;
  localparam logic [7:0] PS2_BAT_OK   = 8'hAA;
  localparam logic [7:0] PS2_BAT_FAIL = 8'hFC;

  // Prefix-sequence state. It is kept as a named 2-bit type so that
  // downstream logic can observe where a multi-byte code currently stands.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } ps2_state_t;

endpackage

// File: rtl/ps2_seq_timer.sv
// Saturating timeout counter for prefix sequences; expired_o flags the last
// allowed idle count so the controller can abort on the following edge.
module ps2_seq_timer #(
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic load_i,
  input  logic [((TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1)-1:0] load_val_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q;

  // Clear wins over load, load wins over counting; counting holds at LAST.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (inc_i && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/ps2_key_flag_ctrl.sv
// Scan-code sequencer: follows F0/E0 prefixes, turns four keys into held
// flags, reports plain make codes and flags truncated sequences / BAT failure.
module ps2_key_flag_ctrl
  import ps2_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 5_000_000,
  parameter logic [7:0] CODE_T0        = 8'h16,
  parameter logic [7:0] CODE_T1        = 8'h1E,
  parameter logic [7:0] CODE_H1        = 8'h26,
  parameter logic [7:0] CODE_E         = 8'h25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  input  logic       pause,
  output logic       rx_en,
  output logic       T0,
  output logic       T1,
  output logic       H1,
  output logic       E,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       seq_err
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  // Flag bit order: {E, H1, T1, T0}.
  localparam logic [3:0][7:0] CODES = {CODE_E, CODE_H1, CODE_T1, CODE_T0};

  ps2_state_t state_q;
  logic [3:0] flags_q;
  logic [7:0] key_code_q;
  logic       key_valid_q;
  logic       seq_err_q;
  logic       rx_en_q;

  logic [3:0] hit;
  logic       tmr_expired;
  logic       timeout;

  // One-hot-ish match of the incoming byte against each assigned key.
  for (genvar gi = 0; gi < 4; gi++) begin : g_hit
    assign hit[gi] = (rx_data == CODES[gi]);
  end

  // A prefix is abandoned only if no byte shows up on the expiring cycle.
  assign timeout = (state_q != IDLE) && tmr_expired && !rx_done_tick;

  ps2_seq_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clr_i     ((state_q == IDLE) || rx_done_tick || timeout),
    .load_i    (1'b0),
    .load_val_i({TW{1'b0}}),
    .inc_i     (state_q != IDLE),
    .expired_o (tmr_expired)
  );

  // Sequencer FSM with all outputs registered on the byte-sampling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      flags_q     <= 4'b0000;
      key_code_q  <= 8'h00;
      key_valid_q <= 1'b0;
      seq_err_q   <= 1'b0;
      rx_en_q     <= 1'b0;
    end else begin
      rx_en_q     <= ~pause;
      key_valid_q <= 1'b0;
      if (rx_done_tick) begin
        case (state_q)
          IDLE: begin
            case (rx_data)
              PS2_BRK:      state_q   <= BRK;
              PS2_EXT:      state_q   <= EXT;
              PS2_BAT_OK:   flags_q   <= 4'b0000;
              PS2_BAT_FAIL: seq_err_q <= 1'b1;
              default: begin
                key_code_q  <= rx_data;
                key_valid_q <= 1'b1;
                flags_q     <= flags_q | hit;
              end
            endcase
          end
          BRK: begin
            flags_q <= flags_q & ~hit;
            state_q <= IDLE;
          end
          EXT: begin
            state_q <= (rx_data == PS2_BRK) ? EXT_BRK : IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end else if (timeout) begin
        state_q   <= IDLE;
        seq_err_q <= 1'b1;
      end
    end
  end

  assign rx_en     = rx_en_q;
  assign T0        = flags_q[0];
  assign T1        = flags_q[1];
  assign H1        = flags_q[2];
  assign E         = flags_q[3];
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_ps2_key_flag_ctrl.sv
// Bench for ps2_key_flag_ctrl: table of byte vectors plus hand-written
// timeout, BAT and reset sequences, checked through an expectation queue.
module tb_ps2_key_flag_ctrl;
  import ps2_pkg::*;

  localparam int TMO = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       pause;
  logic       rx_en, T0, T1, H1, E, key_valid, seq_err;
  logic [7:0] key_code;

  typedef struct {
    logic [7:0] data;
    logic [3:0] flags;  // {E,H1,T1,T0}
    logic [7:0] code;
    logic       kv;
    logic       err;
    ps2_state_t st;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[16];
  int   n_checks = 0;
  int   n_fail   = 0;

  ps2_key_flag_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .pause(pause), .rx_en(rx_en), .T0(T0), .T1(T1), .H1(H1), .E(E),
    .key_code(key_code), .key_valid(key_valid), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Pop the oldest expectation and compare it against the sampled outputs.
  task automatic compare_pop(input string tag);
    vec_t v;
    if (exp_q.size() == 0) begin
      chk({tag, " queue_empty"}, 32'd1, 32'd0);
      return;
    end
    v = exp_q.pop_front();
    chk({tag, " flags"}, {28'd0, E, H1, T1, T0}, {28'd0, v.flags});
    chk({tag, " key_code"}, {24'd0, key_code}, {24'd0, v.code});
    chk({tag, " key_valid"}, {31'd0, key_valid}, {31'd0, v.kv});
    chk({tag, " seq_err"}, {31'd0, seq_err}, {31'd0, v.err});
    chk({tag, " state"}, {30'd0, dut.state_q}, {30'd0, v.st});
    $display("%s: data=%02h flags=%b code=%02h kv=%b err=%b st=%0d",
             tag, v.data, {E, H1, T1, T0}, key_code, key_valid, seq_err, dut.state_q);
  endtask

  function automatic vec_t mk(input logic [7:0] d, input logic [3:0] f, input logic [7:0] c,
                              input logic kv, input logic err, input ps2_state_t st);
    vec_t v;
    v.data = d; v.flags = f; v.code = c; v.kv = kv; v.err = err; v.st = st;
    return v;
  endfunction

  // Drive one byte for one edge; effects are sampled 1 time unit after it.
  task automatic send_byte(input string tag, input vec_t v);
    rx_data      = v.data;
    rx_done_tick = 1'b1;
    exp_q.push_back(v);
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
    compare_pop(tag);
  endtask

  task automatic idle_cycles(input string tag, input int n, input vec_t v);
    rx_done_tick = 1'b0;
    exp_q.push_back(v);
    repeat (n) @(posedge clk);
    #1;
    compare_pop(tag);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rx_done_tick = 1'b0; rx_data = 8'h00; pause = 1'b0;

    tbl[0]  = mk(8'h16, 4'b0001, 8'h16, 1, 0, IDLE);
    tbl[1]  = mk(8'hF0, 4'b0001, 8'h16, 0, 0, BRK);
    tbl[2]  = mk(8'h16, 4'b0000, 8'h16, 0, 0, IDLE);
    tbl[3]  = mk(8'h1E, 4'b0010, 8'h1E, 1, 0, IDLE);
    tbl[4]  = mk(8'h26, 4'b0110, 8'h26, 1, 0, IDLE);
    tbl[5]  = mk(8'h1E, 4'b0110, 8'h1E, 1, 0, IDLE);
    tbl[6]  = mk(8'hF0, 4'b0110, 8'h1E, 0, 0, BRK);
    tbl[7]  = mk(8'h1E, 4'b0100, 8'h1E, 0, 0, IDLE);
    tbl[8]  = mk(8'hE0, 4'b0100, 8'h1E, 0, 0, EXT);
    tbl[9]  = mk(8'h16, 4'b0100, 8'h1E, 0, 0, IDLE);
    tbl[10] = mk(8'hE0, 4'b0100, 8'h1E, 0, 0, EXT);
    tbl[11] = mk(8'hF0, 4'b0100, 8'h1E, 0, 0, EXT_BRK);
    tbl[12] = mk(8'h16, 4'b0100, 8'h1E, 0, 0, IDLE);
    tbl[13] = mk(8'hF0, 4'b0100, 8'h1E, 0, 0, BRK);
    tbl[14] = mk(8'h77, 4'b0100, 8'h1E, 0, 0, IDLE);
    tbl[15] = mk(8'h77, 4'b0100, 8'h77, 1, 0, IDLE);

    // Reset state, rx_en held low while reset is asserted.
    repeat (3) @(posedge clk);
    #1;
    chk("reset rx_en", {31'd0, rx_en}, 32'd0);
    exp_q.push_back(mk(8'h00, 4'b0000, 8'h00, 0, 0, IDLE));
    compare_pop("reset");
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rx_en after reset", {31'd0, rx_en}, 32'd1);

    for (int i = 0; i < 16; i++) begin
      send_byte($sformatf("vec%0d", i), tbl[i]);
      if (i == 0) idle_cycles("vec0 pulse end", 1, mk(8'h00, 4'b0001, 8'h16, 0, 0, IDLE));
    end

    // pause drops rx_en but bytes are still consumed.
    pause = 1'b1;
    @(posedge clk); #1;
    chk("rx_en paused", {31'd0, rx_en}, 32'd0);
    send_byte("paused 16", mk(8'h16, 4'b0101, 8'h16, 1, 0, IDLE));
    pause = 1'b0;

    // Byte on the final allowed cycle beats the timeout.
    send_byte("tmo edge F0", mk(8'hF0, 4'b0101, 8'h16, 0, 0, BRK));
    idle_cycles("tmo edge wait", TMO - 1, mk(8'h00, 4'b0101, 8'h16, 0, 0, BRK));
    send_byte("tmo edge 26", mk(8'h26, 4'b0001, 8'h16, 0, 0, IDLE));

    // Full silence aborts the prefix and sets the sticky error.
    send_byte("tmo F0", mk(8'hF0, 4'b0001, 8'h16, 0, 0, BRK));
    idle_cycles("tmo 99", TMO - 1, mk(8'h00, 4'b0001, 8'h16, 0, 0, BRK));
    idle_cycles("tmo 100", 1, mk(8'h00, 4'b0001, 8'h16, 0, 1, IDLE));
    send_byte("after tmo 25", mk(8'h25, 4'b1001, 8'h25, 1, 1, IDLE));
    idle_cycles("err sticky", 5, mk(8'h00, 4'b1001, 8'h25, 0, 1, IDLE));

    // BAT pass clears flags; BAT fail sets seq_err.
    do_reset(2);
    exp_q.push_back(mk(8'h00, 4'b0000, 8'h00, 0, 0, IDLE));
    compare_pop("reset2");
    send_byte("bat 16", mk(8'h16, 4'b0001, 8'h16, 1, 0, IDLE));
    send_byte("bat 25", mk(8'h25, 4'b1001, 8'h25, 1, 0, IDLE));
    send_byte("bat AA", mk(8'hAA, 4'b0000, 8'h25, 0, 0, IDLE));
    send_byte("bat FC", mk(8'hFC, 4'b0000, 8'h25, 0, 1, IDLE));

    // Reset mid-sequence drops the pending break prefix.
    send_byte("mid F0", mk(8'hF0, 4'b0000, 8'h25, 0, 1, BRK));
    do_reset(1);
    exp_q.push_back(mk(8'h00, 4'b0000, 8'h00, 0, 0, IDLE));
    compare_pop("mid reset");
    send_byte("mid 16", mk(8'h16, 4'b0001, 8'h16, 1, 0, IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
